// File: rtl/bias_bank_seq.sv
// Run-time loadable per-group bias adder that sits between the adder tree and the activation stage.
// Results are registered one cycle after input accept. in_ready = !out_valid | out_ready, so a stalled result holds stable.
module bias_bank_seq #(
  parameter int N_adder_tree = 16,
  parameter int WIDTH        = 18,
  parameter int NUM_GROUPS   = 4,
  parameter int GW           = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_start,
  input  logic                            wr_valid,
  input  logic [WIDTH-1:0]                wr_data,
  output logic                            wr_ready,
  output logic                            loaded,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_adder_tree*WIDTH-1:0]   in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_adder_tree*WIDTH-1:0]   out_data,
  output logic [GW-1:0]                   out_group
);

  localparam int LW = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(N_adder_tree - 1);
  localparam logic [GW-1:0] LAST_GRP  = GW'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t                          state_q;
  logic [LW-1:0]                   lane_q;
  logic [GW-1:0]                   wgrp_q;
  logic [GW-1:0]                   grp_q;
  logic                            loaded_q;
  logic                            out_valid_q;
  logic [N_adder_tree*WIDTH-1:0]   out_data_q;
  logic [N_adder_tree*WIDTH-1:0]   out_data_d;
  logic [GW-1:0]                   out_group_q;
  logic [WIDTH-1:0]                bias_mem [NUM_GROUPS][N_adder_tree];

  logic wr_fire;
  logic in_fire;

  // load_start masks both handshakes so nothing is written or consumed in that cycle.
  assign wr_ready = (state_q == LOAD) && !load_start;
  assign in_ready = (state_q == RUN) && !load_start && (!out_valid_q || out_ready);
  assign wr_fire  = wr_valid && wr_ready;
  assign in_fire  = in_valid && in_ready;

  assign loaded    = loaded_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_group = out_group_q;

  for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   s;
    assign a = in_data[WIDTH*g +: WIDTH];
    assign b = bias_mem[grp_q][g];
    assign s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    // Top two sum bits disagree only on overflow; the carry-out bit gives the direction.
    assign out_data_d[WIDTH*g +: WIDTH] =
      (s[WIDTH] != s[WIDTH-1]) ? (s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}})
                               : s[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bias_mem[wgrp_q][lane_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      lane_q      <= '0;
      wgrp_q      <= '0;
      grp_q       <= '0;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_group_q <= '0;
    end else if (load_start) begin
      state_q     <= LOAD;
      lane_q      <= '0;
      wgrp_q      <= '0;
      grp_q       <= '0;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (lane_q == LAST_LANE) begin
          lane_q <= '0;
          if (wgrp_q == LAST_GRP) begin
            wgrp_q   <= '0;
            state_q  <= RUN;
            loaded_q <= 1'b1;
          end else begin
            wgrp_q <= wgrp_q + 1'b1;
          end
        end else begin
          lane_q <= lane_q + 1'b1;
        end
      end
      if (in_fire) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_group_q <= grp_q;
        if (in_last) begin
          grp_q <= (grp_q == LAST_GRP) ? '0 : grp_q + 1'b1;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bias_bank_seq.sv
// Bench for bias_bank_seq: directed scenarios pinned by literals, then randomized traffic against a behavioural model.
module tb_bias_bank_seq;

  localparam int N  = 4;
  localparam int W  = 18;
  localparam int G  = 2;
  localparam int GW = 1;
  localparam int DW = N * W;
  localparam int MAXV = 131071;
  localparam int MINV = -131072;

  logic          clk;
  logic          rst_n;
  logic          load_start;
  logic          wr_valid;
  logic [W-1:0]  wr_data;
  logic          wr_ready;
  logic          loaded;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [GW-1:0] out_group;

  bias_bank_seq #(.N_adder_tree(N), .WIDTH(W), .NUM_GROUPS(G), .GW(GW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .loaded(loaded),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_group(out_group)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            g;
  } rec_t;

  int   checks = 0;
  int   errors = 0;
  int   bias_m [G][N];
  rec_t exp_q[$];
  rec_t log_q[$];
  bit   m_loading = 0;
  bit   m_loaded = 0;
  int   m_wcnt = 0;
  int   m_ptr = 0;
  bit   room;
  bit   hs_out;
  rec_t r;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    int v[N];
    logic [DW-1:0] res;
    v = '{l0, l1, l2, l3};
    res = '0;
    for (int i = 0; i < N; i++) res[i*W +: W] = W'(v[i]);
    return res;
  endfunction

  function automatic logic [DW-1:0] model_sum(input logic [DW-1:0] d, input int g);
    logic [DW-1:0] res;
    int s;
    res = '0;
    for (int i = 0; i < N; i++) begin
      s = int'($signed(d[i*W +: W])) + bias_m[g][i];
      if (s > MAXV) s = MAXV;
      if (s < MINV) s = MINV;
      res[i*W +: W] = W'(s);
    end
    return res;
  endfunction

  function automatic int rnd_w();
    case ($urandom_range(0, 4))
      0:       return MAXV;
      1:       return MINV;
      default: return int'($urandom_range(0, 262143)) - 131072;
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_vec();
    return pack(rnd_w(), rnd_w(), rnd_w(), rnd_w());
  endfunction

  // Model state is advanced on the falling edge, from the signals that will be sampled at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_loading = 0;
      m_loaded  = 0;
      m_wcnt    = 0;
      m_ptr     = 0;
      check("rst_loaded", loaded, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_group", out_group, 0);
    end else begin
      room   = (exp_q.size() == 0) || out_ready;
      hs_out = (exp_q.size() != 0) && out_ready;
      check("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("out_data", out_data, exp_q[0].d);
        check("out_group", out_group, exp_q[0].g);
      end
      check("loaded", loaded, m_loaded);
      if (!load_start) begin
        check("wr_ready", wr_ready, m_loading);
        check("in_ready", in_ready, m_loaded && room);
      end
      if (load_start) begin
        exp_q.delete();
        m_loading = 1;
        m_loaded  = 0;
        m_wcnt    = 0;
        m_ptr     = 0;
      end else begin
        if (hs_out) log_q.push_back(exp_q.pop_front());
        if (m_loaded && in_valid && room) begin
          r.d = model_sum(in_data, m_ptr);
          r.g = m_ptr;
          exp_q.push_back(r);
          if (in_last) m_ptr = (m_ptr + 1) % G;
        end
        if (m_loading && wr_valid) begin
          bias_m[m_wcnt / N][m_wcnt % N] = int'($signed(wr_data));
          m_wcnt++;
          if (m_wcnt == G * N) begin
            m_loading = 0;
            m_loaded  = 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic load_words(input int w[8], input int cnt);
    bit acc;
    int n;
    for (int k = 0; k < cnt; k++) begin
      wr_valid = 1'b1;
      wr_data  = W'(w[k]);
      acc = 0;
      n   = 0;
      while (!acc && n < 50) begin
        @(negedge clk);
        acc = wr_ready;
        step();
        n++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL wr_accept_timeout: word %0d not accepted, wr_ready=%0b expected 1", k, wr_ready);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit last, output int waited);
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    acc    = 0;
    waited = 0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = in_ready;
      step();
      waited++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL in_accept_timeout: beat not accepted, in_ready=%0b expected 1", in_ready);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_log(input string name, input int idx, input logic [DW-1:0] d, input int g);
    if (idx >= log_q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: result %0d missing, seen %0d results, expected at least %0d", name, idx, log_q.size(), idx + 1);
    end else begin
      check({name, "_data"}, log_q[idx].d, d);
      check({name, "_grp"}, log_q[idx].g, g);
    end
  endtask

  task automatic random_round(input int cycles);
    int  w[8];
    bit  acc;
    for (int k = 0; k < 8; k++) w[k] = rnd_w();
    pulse_load();
    load_words(w, 8);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = rnd_vec();
        in_last  = ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_data   = W'($urandom);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    wr_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    int w[8];
    int waited;
    rst_n = 1'b1; load_start = 1'b0; wr_valid = 1'b0; wr_data = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) step();
    check("idle_loaded", loaded, 0);
    check("idle_wr_ready", wr_ready, 0);
    check("idle_in_ready", in_ready, 0);

    // Basic load and add, pointer wraps after group 1.
    pulse_load();
    w = '{1, 2, 3, 4, -1, -2, -3, -4};
    load_words(w, 8);
    check("loaded_after_8", loaded, 1);
    log_q.delete();
    out_ready = 1'b1;
    send_beat(pack(10, 10, 10, 10), 1, waited);
    send_beat(pack(0, 0, 0, 0), 1, waited);
    send_beat(pack(0, 0, 0, 0), 0, waited);
    repeat (3) step();
    check_log("add_g0", 0, pack(11, 12, 13, 14), 0);
    check_log("add_g1", 1, pack(-1, -2, -3, -4), 1);
    check_log("add_wrap", 2, pack(1, 2, 3, 4), 0);

    // Saturation at both rails, and exact-boundary sums that must not clamp.
    pulse_load();
    w = '{MAXV, MINV, 0, 0, 0, 0, 0, 0};
    load_words(w, 8);
    log_q.delete();
    send_beat(pack(5, -1, MAXV, -5), 0, waited);
    send_beat(pack(MINV, MAXV, MINV, 0), 0, waited);
    repeat (3) step();
    check_log("sat_clamp", 0, pack(MAXV, MINV, MAXV, -5), 0);
    check_log("sat_edge", 1, pack(-1, -1, MINV, 0), 0);

    // Backpressure: result holds while the next beat waits.
    log_q.delete();
    out_ready = 1'b0;
    send_beat(pack(1, 2, 3, 4), 0, waited);
    in_valid = 1'b1;
    in_data  = pack(5, 5, 5, 5);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, pack(MAXV, -131070, 3, 4));
      step();
    end
    out_ready = 1'b1;
    send_beat(pack(5, 5, 5, 5), 0, waited);
    repeat (3) step();
    check("bp_count", log_q.size(), 2);
    check_log("bp_first", 0, pack(MAXV, -131070, 3, 4), 0);
    check_log("bp_second", 1, pack(MAXV, -131067, 5, 5), 0);
    for (int k = 0; k < 4; k++) begin
      send_beat(pack(k, k, k, k), 0, waited);
      check("stream_no_stall", waited, 1);
    end
    repeat (3) step();

    // load_start beats a pending result and a same-cycle write.
    out_ready = 1'b0;
    send_beat(pack(1, 1, 1, 1), 0, waited);
    check("pre_reload_valid", out_valid, 1);
    log_q.delete();
    load_start = 1'b1;
    wr_valid   = 1'b1;
    wr_data    = W'(999);
    step();
    load_start = 1'b0;
    check("reload_out_valid", out_valid, 0);
    check("reload_loaded", loaded, 0);
    w = '{7, 0, 0, 0, 0, 0, 0, 0};
    load_words(w, 8);
    out_ready = 1'b1;
    send_beat(pack(0, 0, 0, 0), 0, waited);
    repeat (3) step();
    check("reload_count", log_q.size(), 1);
    check_log("reload_first_word", 0, pack(7, 0, 0, 0), 0);

    // Asynchronous reset in the middle of a load.
    pulse_load();
    w = '{9, 9, 9, 9, 9, 9, 9, 9};
    load_words(w, 3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_wr_ready", wr_ready, 0);
    check("arst_loaded", loaded, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    #4 rst_n = 1'b1;
    repeat (5) step();
    check("arst_still_unloaded", loaded, 0);

    random_round(1500);
    random_round(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
